// File: rtl/egress_ctrl.sv
// egress_ctrl: turns packet descriptors (address + byte length) into one AXI4
// INCR read burst each and re-emits the returned data as an AXI-Stream packet.
//
// Ports
//   clk, rst_n            single clock, asynchronous active-low reset
//   rd_en                 allows new descriptors to be accepted
//   desc_*                descriptor handshake (addr, len in bytes, valid/ready)
//   m_axi_ar*             AXI4 read address channel (one burst outstanding)
//   m_axi_r*              AXI4 read data channel
//   m_axis_t*             AXI-Stream packet output, driven from registers only
//   pkt_cnt               packets emitted (wrapping 32-bit count)
//   err                   sticky: bad descriptor length or rlast disagreement
//   fsm_state             current FSM state (0 IDLE, 1 ADDR, 2 DATA)
//
// Handshake rule for every valid/ready pair here: a transfer happens on a rising
// edge where both are high; a source holding valid keeps its payload stable and
// never withdraws valid until that transfer, and ready may depend on state only.
module egress_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 512
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   desc_addr,
    input  logic [15:0]             desc_len,
    input  logic                    desc_valid,
    output logic                    desc_ready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [31:0]             pkt_cnt,
    output logic                    err,
    output logic [1:0]              fsm_state
);
    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int SHIFT      = $clog2(BEAT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {{(ADDR_WIDTH-SHIFT){1'b1}}, {SHIFT{1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              arlen_q;
    logic [SHIFT-1:0]        rem_q;
    logic [8:0]              beats_left;
    logic [8:0]              beats_calc;
    logic                    len_ok;
    logic                    desc_fire, ar_fire, r_fire, t_fire, final_beat;
    logic [BEAT_BYTES-1:0]   keep_final;

    // two-entry output buffer; the stream outputs read straight from it
    logic [DATA_WIDTH-1:0]   buf_data [2];
    logic [BEAT_BYTES-1:0]   buf_keep [2];
    logic                    buf_last [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              count;

    assign len_ok     = (desc_len != 16'd0) && (desc_len <= 16'd16384);
    // ceil(len / BEAT_BYTES): whole beats plus one if any bytes remain
    assign beats_calc = 9'((desc_len >> SHIFT) + 16'(|desc_len[SHIFT-1:0]));
    assign desc_fire  = desc_valid && desc_ready;
    assign ar_fire    = m_axi_arvalid && m_axi_arready;
    assign r_fire     = m_axi_rvalid && m_axi_rready;
    assign t_fire     = m_axis_tvalid && m_axis_tready;
    // the burst length we asked for decides the end, not rlast
    assign final_beat = (beats_left == 9'd1);
    assign keep_final = (rem_q == '0) ? {BEAT_BYTES{1'b1}} : ~({BEAT_BYTES{1'b1}} << rem_q);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (desc_fire && len_ok) state_nxt = ADDR;
            ADDR:    if (ar_fire) state_nxt = DATA;
            DATA:    if (r_fire && final_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        desc_ready    = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state)
            IDLE:    desc_ready    = rd_en && rst_n;
            ADDR:    m_axi_arvalid = 1'b1;
            DATA:    m_axi_rready  = (count != 2'd2);
            default: ;
        endcase
    end

    assign m_axi_araddr  = addr_q & ADDR_MASK;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(SHIFT);
    assign m_axi_arburst = 2'b01;
    assign fsm_state     = state;

    // descriptor latch, beat counter, sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            arlen_q    <= '0;
            rem_q      <= '0;
            beats_left <= '0;
            err        <= 1'b0;
        end else begin
            if (desc_fire) begin
                if (len_ok) begin
                    addr_q     <= desc_addr;
                    arlen_q    <= 8'(beats_calc - 9'd1);
                    rem_q      <= desc_len[SHIFT-1:0];
                    beats_left <= beats_calc;
                end else begin
                    err <= 1'b1;
                end
            end
            if (r_fire) begin
                beats_left <= beats_left - 9'd1;
                if (m_axi_rlast != final_beat) err <= 1'b1;
            end
        end
    end

    // output buffer and packet counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_keep[i] <= '0;
                buf_last[i] <= 1'b0;
            end
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            pkt_cnt <= 32'd0;
        end else begin
            if (r_fire) begin
                buf_data[wr_ptr] <= m_axi_rdata;
                buf_keep[wr_ptr] <= final_beat ? keep_final : {BEAT_BYTES{1'b1}};
                buf_last[wr_ptr] <= final_beat;
                wr_ptr           <= ~wr_ptr;
            end
            if (t_fire) begin
                rd_ptr <= ~rd_ptr;
                if (m_axis_tlast) pkt_cnt <= pkt_cnt + 32'd1;
            end
            case ({r_fire, t_fire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign m_axis_tvalid = (count != 2'd0);
    assign m_axis_tdata  = buf_data[rd_ptr];
    assign m_axis_tkeep  = buf_keep[rd_ptr];
    assign m_axis_tlast  = buf_last[rd_ptr];

endmodule

// File: tb/tb_egress_ctrl.sv
// Directed bench for egress_ctrl with a packet-level reference model, an AXI
// read slave, and a per-cycle compare process.
module tb_egress_ctrl;
    localparam int AW = 16;
    localparam int DW = 512;
    localparam int KW = 64;
    localparam int EW = DW + KW + 1;
    localparam int CW = 600;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_en, desc_valid, desc_ready;
    logic [AW-1:0] desc_addr;
    logic [15:0]   desc_len;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arvalid, m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic [31:0]   pkt_cnt;
    logic          err;
    logic [1:0]    fsm_state;

    always #5 clk = ~clk;

    egress_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
        .desc_addr(desc_addr), .desc_len(desc_len), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .pkt_cnt(pkt_cnt), .err(err), .fsm_state(fsm_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [DW-1:0] mk_data(input int tag, input int idx);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = {tag[15:0], idx[7:0], 8'(i)};
        return d;
    endfunction

    // ---------------- reference model state ----------------
    logic [EW-1:0]   exp_q[$];
    logic [AW+7:0]   exp_ar[$];
    int              m_tag = 0;
    logic            exp_err = 1'b0;
    logic [31:0]     exp_pkt = 32'd0;
    int              outstanding = 0;
    int              ar_hist[$];
    logic [KW-1:0]   keep_hist[$];
    int              beats_hist[$];
    int              span_hist[$];
    int              beat_in_pkt = 0;
    int              pkt_start = 0;
    int              cyc = 0;
    logic            prev_stall = 1'b0;
    logic [EW-1:0]   prev_t;
    logic            prev_ar_stall = 1'b0;
    logic [AW+7:0]   prev_ar;

    // slave state
    int              s_beats[$];
    int              s_tags[$];
    int              s_tag = 0;
    int              r_idx = 0;
    logic            rlast_drop = 1'b0;
    logic            r_bad = 1'b0;

    // tready driver
    logic            tready_rand = 1'b0;
    logic            tready_fix = 1'b1;

    // A packet of len bytes is ceil(len/64) beats; all bytes valid except the
    // tail of the last beat; address aligned down to 64 bytes.
    task automatic model_accept(input logic [AW-1:0] addr, input int len);
        int beats, rem;
        logic [KW-1:0] ones, keep;
        if (len == 0 || len > 16384) begin
            exp_err = 1'b1;
        end else begin
            beats = (len + 63) / 64;
            rem   = len % 64;
            ones  = '1;
            exp_ar.push_back({addr & 16'hFFC0, 8'(beats - 1)});
            for (int b = 0; b < beats; b++) begin
                keep = (b == beats - 1 && rem != 0) ? (ones >> (KW - rem)) : ones;
                exp_q.push_back({mk_data(m_tag, b), keep, (b == beats - 1)});
            end
            m_tag++;
            outstanding += beats;
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        logic [EW-1:0] e;
        logic [AW+7:0] ea;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                exp_ar.delete();
                exp_err = 1'b0;
                exp_pkt = 32'd0;
                outstanding = 0;
                beat_in_pkt = 0;
                prev_stall = 1'b0;
                prev_ar_stall = 1'b0;
            end else begin
                cyc++;
                chk("err", err, exp_err);
                chk("pkt_cnt", pkt_cnt, exp_pkt);
                if (outstanding > 0) chk("desc_ready while busy", desc_ready, 0);
                if (prev_ar_stall) chk("ar hold", {m_axi_arvalid, m_axi_araddr, m_axi_arlen}, {1'b1, prev_ar});
                if (prev_stall) chk("t hold", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast}, {1'b1, prev_t});
                if (m_axi_arvalid && m_axi_arready) begin
                    if (exp_ar.size() == 0) fail_now("unexpected AR");
                    else begin
                        ea = exp_ar.pop_front();
                        chk("araddr/arlen", {m_axi_araddr, m_axi_arlen}, ea);
                        chk("arsize", m_axi_arsize, 3'd6);
                        chk("arburst", m_axi_arburst, 2'd1);
                        ar_hist.push_back(int'(m_axi_arlen));
                    end
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) fail_now("unexpected stream beat");
                    else begin
                        e = exp_q.pop_front();
                        chk("stream beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, e);
                        if (beat_in_pkt == 0) pkt_start = cyc;
                        beat_in_pkt++;
                        if (e[0]) begin
                            exp_pkt++;
                            keep_hist.push_back(m_axis_tkeep);
                            beats_hist.push_back(beat_in_pkt);
                            span_hist.push_back(cyc - pkt_start);
                            beat_in_pkt = 0;
                        end
                    end
                end
                if (m_axi_rvalid && m_axi_rready) begin
                    if (outstanding > 0) outstanding--;
                    if (r_bad) exp_err = 1'b1;
                end
                if (desc_valid && desc_ready) model_accept(desc_addr, int'(desc_len));
                prev_stall    = m_axis_tvalid && !m_axis_tready;
                prev_t        = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
                prev_ar_stall = m_axi_arvalid && !m_axi_arready;
                prev_ar       = {m_axi_araddr, m_axi_arlen};
            end
        end
    end

    // ---------------- AXI read slave ----------------
    initial begin
        logic arf, rf, is_last;
        logic [7:0] arl;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rlast   = 1'b0;
        forever begin
            @(negedge clk);
            arf = m_axi_arvalid && m_axi_arready;
            rf  = m_axi_rvalid && m_axi_rready;
            arl = m_axi_arlen;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                s_beats.delete();
                s_tags.delete();
                r_idx = 0;
                m_axi_rvalid = 1'b0;
                m_axi_rlast = 1'b0;
                m_axi_arready = 1'b0;
                r_bad = 1'b0;
            end else begin
                if (rf && s_beats.size() > 0) begin
                    r_idx++;
                    if (r_idx == s_beats[0]) begin
                        void'(s_beats.pop_front());
                        void'(s_tags.pop_front());
                        r_idx = 0;
                    end
                end
                if (arf) begin
                    s_beats.push_back(int'(arl) + 1);
                    s_tags.push_back(s_tag);
                    s_tag++;
                end
                m_axi_arready = 1'($urandom_range(0, 1));
                if (s_beats.size() > 0) begin
                    is_last      = (r_idx == s_beats[0] - 1);
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = mk_data(s_tags[0], r_idx);
                    m_axi_rlast  = is_last && !rlast_drop;
                    r_bad        = (m_axi_rlast != is_last);
                end else begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                    r_bad        = 1'b0;
                end
            end
        end
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = tready_rand ? 1'($urandom_range(0, 1)) : tready_fix;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_desc(input logic [AW-1:0] addr, input int len);
        int n;
        @(posedge clk);
        #1;
        desc_addr  = addr;
        desc_len   = 16'(len);
        desc_valid = 1'b1;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (desc_ready) break;
        end
        if (n == 300) fail_now("descriptor accept timeout");
        @(posedge clk);
        #1;
        desc_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0 && exp_ar.size() == 0 && s_beats.size() == 0 && outstanding == 0) break;
        end
        if (n == budget) fail_now("drain timeout");
        repeat (2) @(negedge clk);
        #2;
    endtask

    task automatic clear_hist();
        ar_hist.delete();
        keep_hist.delete();
        beats_hist.delete();
        span_hist.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " desc_ready"}, desc_ready, 0);
        chk({tag, " arvalid"}, m_axi_arvalid, 0);
        chk({tag, " rready"}, m_axi_rready, 0);
        chk({tag, " tvalid"}, m_axis_tvalid, 0);
        chk({tag, " tlast"}, m_axis_tlast, 0);
        chk({tag, " tkeep"}, m_axis_tkeep, 0);
        chk({tag, " tdata"}, m_axis_tdata, 0);
        chk({tag, " pkt_cnt"}, pkt_cnt, 0);
        chk({tag, " err"}, err, 0);
        chk({tag, " state"}, fsm_state, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        rd_en = 1'b1;
        desc_valid = 1'b0;
        desc_addr = '0;
        desc_len = '0;
        #12;
        chk_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single short packet
        clear_hist();
        send_desc(16'h0040, 61);
        wait_drain(100);
        chk("t1 ar count", ar_hist.size(), 1);
        chk("t1 arlen", ar_hist[0], 0);
        chk("t1 beats", beats_hist[0], 1);
        chk("t1 tkeep", keep_hist[0], 64'h1FFF_FFFF_FFFF_FFFF);
        chk("t1 pkt_cnt", pkt_cnt, 1);

        // back-to-back packets, full throughput
        clear_hist();
        send_desc(16'h1000, 400);
        send_desc(16'h2010, 1200);
        wait_drain(200);
        chk("t2 arlen a", ar_hist[0], 6);
        chk("t2 arlen b", ar_hist[1], 18);
        chk("t2 keep a", keep_hist[0], 64'h0000_0000_0000_FFFF);
        chk("t2 keep b", keep_hist[1], 64'h0000_FFFF_FFFF_FFFF);
        chk("t2 beats a", beats_hist[0], 7);
        chk("t2 beats b", beats_hist[1], 19);
        chk("t2 span a", span_hist[0], 6);
        chk("t2 span b", span_hist[1], 18);
        chk("t2 pkt_cnt", pkt_cnt, 3);

        // random backpressure during a 1200-byte packet
        clear_hist();
        tready_rand = 1'b1;
        send_desc(16'h3000, 1200);
        wait_drain(600);
        tready_rand = 1'b0;
        chk("t3 beats", beats_hist[0], 19);
        chk("t3 pkt_cnt", pkt_cnt, 4);

        // rlast missing on the final beat: data still forwarded, err set
        clear_hist();
        rlast_drop = 1'b1;
        send_desc(16'h4000, 200);
        wait_drain(100);
        rlast_drop = 1'b0;
        chk("t4 beats", beats_hist[0], 4);
        chk("t4 keep", keep_hist[0], 64'h0000_0000_0000_00FF);
        chk("t4 err", err, 1);
        chk("t4 pkt_cnt", pkt_cnt, 5);

        // reset during beat 3 of an 800-byte read
        send_desc(16'h5000, 800);
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (r_idx >= 3) break;
        end
        if (n == 200) fail_now("beat 3 wait timeout");
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid-burst reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_hist();
        send_desc(16'h6000, 64);
        wait_drain(100);
        chk("t5 ar count", ar_hist.size(), 1);
        chk("t5 arlen", ar_hist[0], 0);
        chk("t5 beats", beats_hist[0], 1);
        chk("t5 keep", keep_hist[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t5 pkt_cnt", pkt_cnt, 1);
        chk("t5 err", err, 0);

        // bad lengths are consumed without any read
        clear_hist();
        send_desc(16'h7000, 0);
        send_desc(16'h7000, 17000);
        wait_drain(50);
        chk("t6 no AR", ar_hist.size(), 0);
        chk("t6 err", err, 1);
        chk("t6 desc_ready", desc_ready, 1);
        send_desc(16'h7040, 46);
        wait_drain(100);
        chk("t6 keep", keep_hist[0], 64'h0000_3FFF_FFFF_FFFF);
        chk("t6 pkt_cnt", pkt_cnt, 2);

        // rd_en low blocks acceptance
        clear_hist();
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        desc_addr = 16'h0100;
        desc_len = 16'd128;
        desc_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t7 desc_ready low", desc_ready, 0);
            chk("t7 arvalid low", m_axi_arvalid, 0);
        end
        @(posedge clk);
        #1;
        rd_en = 1'b1;
        @(negedge clk);
        chk("t7 desc_ready high", desc_ready, 1);
        @(posedge clk);
        #1;
        desc_valid = 1'b0;
        wait_drain(100);
        chk("t7 beats", beats_hist[0], 2);
        chk("t7 keep", keep_hist[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t7 pkt_cnt", pkt_cnt, 3);

        // rd_en dropped mid-packet does not abort it
        clear_hist();
        send_desc(16'h0800, 1200);
        rd_en = 1'b0;
        wait_drain(200);
        chk("t8 beats", beats_hist[0], 19);
        chk("t8 pkt_cnt", pkt_cnt, 4);
        chk("t8 desc_ready", desc_ready, 0);
        rd_en = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/egress_ctrl.md
EGRESS_CTRL -- requirements
Module: egress_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, AXI byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 512, AXI/AXIS data width; BEAT_BYTES = DATA_WIDTH/8 (64).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rd_en  input  1  enable descriptor acceptance.
REQ-006 SHALL have ports desc_addr (in, ADDR_WIDTH), desc_len (in, 16, packet bytes), desc_valid (in, 1), desc_ready (out, 1): packet descriptor handshake.
REQ-007 SHALL have ports m_axi_araddr (out, ADDR_WIDTH), m_axi_arlen (out, 8), m_axi_arsize (out, 3), m_axi_arburst (out, 2), m_axi_arvalid (out, 1), m_axi_arready (in, 1): AXI4 read address.
REQ-008 SHALL have ports m_axi_rdata (in, DATA_WIDTH), m_axi_rlast (in, 1), m_axi_rvalid (in, 1), m_axi_rready (out, 1): AXI4 read data.
REQ-009 SHALL have ports m_axis_tdata (out, DATA_WIDTH), m_axis_tkeep (out, DATA_WIDTH/8), m_axis_tlast (out, 1), m_axis_tvalid (out, 1), m_axis_tready (in, 1): AXI-Stream packet output.
REQ-010 SHALL have ports pkt_cnt (out, 32, packets emitted) and err (out, 1, sticky error flag).

Function
REQ-011 SHALL implement FSM states IDLE, ADDR, DATA.
REQ-012 IDLE: desc_ready = rd_en; on desc_valid && desc_ready, latch descriptor, compute beats = ceil(desc_len/64), go to ADDR.
REQ-013 desc_len of 0 or > 16384 SHALL be consumed, set err, and remain in IDLE with no AXI transaction.
REQ-014 ADDR: m_axi_arvalid=1, araddr = latched addr with low 6 bits forced 0, arlen = beats-1, arsize = 3'b110, arburst = 2'b01 (INCR); hold stable until arready; then go to DATA.
REQ-015 Exactly one burst outstanding; no new descriptor accepted outside IDLE.
REQ-016 DATA: m_axi_rready = 1 whenever the 2-entry output skid buffer has a free slot; each R handshake writes one entry and decrements the beat counter.
REQ-017 Final beat determined by beat counter, not rlast; rlast asserted early or missing on final beat SHALL set err (data still forwarded as counted).
REQ-018 After last R handshake, return to IDLE next cycle; desc_ready may assert that cycle while skid buffer drains.
REQ-019 Output from skid buffer registers only (no combinational rdata->tdata path); tvalid/tdata/tkeep/tlast stable while tvalid && !tready.
REQ-020 tkeep = all ones except final beat: low (desc_len mod 64) bits set; all ones if remainder is 0.
REQ-021 tlast = 1 only on final beat of each packet.
REQ-022 Full-throughput: with tready=1 and rvalid=1 continuously, one beat per cycle.
REQ-023 pkt_cnt increments by 1 on each tvalid && tready && tlast; wraps at 2^32.
REQ-024 rd_en deasserted mid-packet SHALL NOT abort the current packet; only blocks next descriptor.

Reset
REQ-025 rst_n low asynchronously SHALL force: FSM IDLE, desc_ready 0, arvalid 0, rready 0, tvalid 0, tlast 0, tkeep 0, tdata 0, skid buffer empty, pkt_cnt 0, err 0.
REQ-026 Reset mid-burst SHALL discard in-flight state; after release, first accepted descriptor starts a fresh burst.

Verification
REQ-027 rd_en=1, desc (addr 0x0040, len 61), tready=1 -> one AR arlen=0, arsize=6, arburst=1; one output beat, tkeep=61 low bits set, tlast=1, pkt_cnt=1.
REQ-028 Desc len 400 then len 1200 back-to-back -> arlen 6 then 18; last beats tkeep 16 and 48 low bits set; 7+19 beats, pkt_cnt=2.
REQ-029 tready toggled 50% random during 1200-byte packet, rvalid continuous -> all 19 beats in order, no loss/duplication, outputs stable while stalled.
REQ-030 desc len 0, then len 17000 -> no AR issued, err=1, desc_ready returns high; following len 46 packet emitted normally.
REQ-031 rst_n pulsed low during beat 3 of 800-byte read -> all outputs to reset values immediately; subsequent len 64 packet -> one beat, tkeep all ones, pkt_cnt=1.
REQ-032 rd_en=0 with desc_valid=1 for 20 cycles -> desc_ready=0, arvalid=0; rd_en=1 -> descriptor accepted next cycle.
